imem_boot_loader: RTL

Boot-time sequencer for the single-cycle CPU. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory through the CPU's `initialize` / `instruction_initialize_address` / `instruction_initialize_data` port. It holds the CPU in reset for the whole load and for a programmable settle interval afterwards, then releases it to run. A later `start` reloads a new program.

---
 rtl/imem_boot_loader.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams instruction words into the CPU instruction memory,
// holds the CPU in reset through the load plus a settle interval, then releases it.
module imem_boot_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int RST_HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        initialize,
    output logic        instruction_initialize_write,
    output logic [31:0] instruction_initialize_address,
    output logic [31:0] instruction_initialize_data,
    output logic        cpu_rst,
    output logic        done,
    output logic [15:0] word_count,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    localparam logic [15:0] DEPTH     = 16'(DEPTH_WORDS);
    localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);

    state_t      state;
    logic [15:0] hold_cnt;

    // word_count doubles as the write index: it only advances on real writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                          <= IDLE;
            hold_cnt                       <= '0;
            load_ready                     <= 1'b0;
            initialize                     <= 1'b0;
            instruction_initialize_write   <= 1'b0;
            instruction_initialize_address <= '0;
            instruction_initialize_data    <= '0;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            word_count                     <= '0;
            overflow                       <= 1'b0;
        end else begin
            instruction_initialize_write <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_rst <= 1'b1;
                    if (start) begin
                        state      <= LOAD;
                        initialize <= 1'b1;
                        load_ready <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready) begin
                        if (word_count < DEPTH) begin
                            instruction_initialize_address <= {14'b0, word_count, 2'b00};
                            instruction_initialize_data    <= load_data;
                            instruction_initialize_write   <= 1'b1;
                            word_count                     <= word_count + 16'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (load_last) begin
                            state      <= HOLD;
                            load_ready <= 1'b0;
                            hold_cnt   <= HOLD_INIT;
                        end
                    end
                end
                HOLD: begin
                    // First HOLD cycle still carries the final strobe; count after it.
                    if (initialize) begin
                        initialize <= 1'b0;
                    end else if (hold_cnt == 16'd0) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                RUN: begin
                    if (start) begin
                        state      <= LOAD;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        initialize <= 1'b1;
                        load_ready <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
